// File: rtl/sfp_link_pkg.sv
// sfp_link_pkg: shared state encodings and derived sizing for the SFP frame link.
//   C_*_DEF : default frame / stream / RX timeout values used by the modules.
//   N       : stream beats per frame at the default widths.
//   IDX_W   : beat index / word count width at the default widths.
package sfp_link_pkg;

  localparam int C_DATA_FRAME_BIT_DEF = 128;
  localparam int C_STREAM_WIDTH_DEF   = 32;
  localparam int C_RX_TIMEOUT_DEF     = 255;

  function automatic int beats(input int frame_bits, input int word_bits);
    return frame_bits / word_bits;
  endfunction

  // A one-beat frame still needs a 1-bit index register.
  function automatic int idx_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int N     = beats(C_DATA_FRAME_BIT_DEF, C_STREAM_WIDTH_DEF);
  localparam int IDX_W = idx_bits(N);

  typedef enum logic {
    TX_IDLE,
    TX_SEND
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_RUN,
    RX_DISCARD
  } rx_state_e;

endpackage

// File: rtl/sfp_rx_assembler.sv
// sfp_rx_assembler: rebuilds parallel frames from the incoming stream.
//   clk, rst_n             : clock, async active-low reset
//   i_channel_up           : link up; low aborts a partial frame silently
//   i_tdata/i_tvalid/i_tlast : RX stream (never back-pressured)
//   o_rx_frame             : last good frame, held until the next good one
//   o_end_flag / o_rx_err  : one-cycle good-frame / dropped-frame pulses
//   o_rx_frame_cnt, o_rx_err_cnt : wrapping event counters
//
// state      | meaning
// RX_IDLE    | no partial frame; next beat starts a new frame
// RX_RUN     | partial frame in the accumulator; idle timer armed
// RX_DISCARD | overlong frame; drop beats through the next tlast
module sfp_rx_assembler
  import sfp_link_pkg::*;
#(
  parameter int C_DATA_FRAME_BIT = C_DATA_FRAME_BIT_DEF,
  parameter int C_STREAM_WIDTH   = C_STREAM_WIDTH_DEF,
  parameter int C_RX_TIMEOUT     = C_RX_TIMEOUT_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_channel_up,
  input  logic [C_STREAM_WIDTH-1:0]   i_tdata,
  input  logic                        i_tvalid,
  input  logic                        i_tlast,
  output logic [C_DATA_FRAME_BIT-1:0] o_rx_frame,
  output logic                        o_end_flag,
  output logic                        o_rx_err,
  output logic [15:0]                 o_rx_frame_cnt,
  output logic [15:0]                 o_rx_err_cnt
);

  localparam int NB = beats(C_DATA_FRAME_BIT, C_STREAM_WIDTH);
  localparam int IW = idx_bits(NB);
  localparam int TW = (C_RX_TIMEOUT > 1) ? $clog2(C_RX_TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
  // Down-counter reloads on every beat; reaching zero after C_RX_TIMEOUT idle cycles.
  localparam logic [TW-1:0] TMO_LOAD = TW'(C_RX_TIMEOUT - 1);

  rx_state_e                   state_q, state_d;
  logic [C_DATA_FRAME_BIT-1:0] acc_q, acc_d;
  logic [C_DATA_FRAME_BIT-1:0] frame_q, frame_d;
  logic [IW-1:0]               cnt_q, cnt_d;
  logic [TW-1:0]               timer_q, timer_d;
  logic                        end_q, end_d;
  logic                        err_q, err_d;
  logic [15:0]                 frame_cnt_q, frame_cnt_d;
  logic [15:0]                 err_cnt_q, err_cnt_d;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    frame_d     = frame_q;
    cnt_d       = cnt_q;
    timer_d     = timer_q;
    end_d       = 1'b0;
    err_d       = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (!i_channel_up) begin
      state_d = RX_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        RX_IDLE, RX_RUN: begin
          if (i_tvalid) begin
            // A beat always beats the timeout, even in the terminal cycle.
            acc_d   = (acc_q << C_STREAM_WIDTH) | C_DATA_FRAME_BIT'(i_tdata);
            timer_d = TMO_LOAD;
            if (i_tlast) begin
              state_d = RX_IDLE;
              cnt_d   = '0;
              if (cnt_q == LAST_IDX) begin
                frame_d     = acc_d;
                end_d       = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
              end else begin
                err_d     = 1'b1;
                err_cnt_d = err_cnt_q + 16'd1;
              end
            end else if (cnt_q == LAST_IDX) begin
              err_d     = 1'b1;
              err_cnt_d = err_cnt_q + 16'd1;
              cnt_d     = '0;
              state_d   = RX_DISCARD;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = RX_RUN;
            end
          end else if (state_q == RX_RUN) begin
            if (timer_q == '0) begin
              err_d     = 1'b1;
              err_cnt_d = err_cnt_q + 16'd1;
              cnt_d     = '0;
              state_d   = RX_IDLE;
            end else begin
              timer_d = timer_q - 1'b1;
            end
          end
        end
        RX_DISCARD: begin
          if (i_tvalid && i_tlast) state_d = RX_IDLE;
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RX_IDLE;
      acc_q       <= '0;
      frame_q     <= '0;
      cnt_q       <= '0;
      timer_q     <= TMO_LOAD;
      end_q       <= 1'b0;
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      frame_q     <= frame_d;
      cnt_q       <= cnt_d;
      timer_q     <= timer_d;
      end_q       <= end_d;
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_rx_frame     = frame_q;
  assign o_end_flag     = end_q;
  assign o_rx_err       = err_q;
  assign o_rx_frame_cnt = frame_cnt_q;
  assign o_rx_err_cnt   = err_cnt_q;

endmodule

// File: rtl/sfp_frame_link.sv
// sfp_frame_link: bridge between the MPS control block and the SFP transceiver.
//   S_AXI_ACLK, S_AXI_ARESETN : clock, async active-low reset
//   i_channel_up              : transceiver link up
//   i_sfp_start_flag, i_tx_frame, o_tx_en : TX frame request / ready
//   m_axis_*                  : TX stream, most significant word first
//   s_axis_*                  : RX stream into sfp_rx_assembler
//   o_rx_frame, o_sfp_end_flag, o_rx_err : RX frame and event pulses
//   o_tx_frame_cnt, o_rx_frame_cnt, o_rx_err_cnt : wrapping counters
//
// state   | meaning
// TX_IDLE | waiting for a start pulse; o_tx_en follows link up
// TX_SEND | shifting the latched frame out one word per handshake
module sfp_frame_link
  import sfp_link_pkg::*;
#(
  parameter int C_DATA_FRAME_BIT = C_DATA_FRAME_BIT_DEF,
  parameter int C_STREAM_WIDTH   = C_STREAM_WIDTH_DEF,
  parameter int C_RX_TIMEOUT     = C_RX_TIMEOUT_DEF
) (
  input  logic                        S_AXI_ACLK,
  input  logic                        S_AXI_ARESETN,
  input  logic                        i_channel_up,
  input  logic                        i_sfp_start_flag,
  input  logic [C_DATA_FRAME_BIT-1:0] i_tx_frame,
  output logic                        o_tx_en,
  output logic [C_STREAM_WIDTH-1:0]   m_axis_tdata,
  output logic                        m_axis_tvalid,
  output logic                        m_axis_tlast,
  input  logic                        m_axis_tready,
  input  logic [C_STREAM_WIDTH-1:0]   s_axis_tdata,
  input  logic                        s_axis_tvalid,
  input  logic                        s_axis_tlast,
  output logic [C_DATA_FRAME_BIT-1:0] o_rx_frame,
  output logic                        o_sfp_end_flag,
  output logic                        o_rx_err,
  output logic [15:0]                 o_tx_frame_cnt,
  output logic [15:0]                 o_rx_frame_cnt,
  output logic [15:0]                 o_rx_err_cnt
);

  localparam int NB = beats(C_DATA_FRAME_BIT, C_STREAM_WIDTH);
  localparam int IW = idx_bits(NB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  tx_state_e                   state_q, state_d;
  logic [C_DATA_FRAME_BIT-1:0] shreg_q, shreg_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic                        tvalid_q, tvalid_d;
  logic                        tx_en_q, tx_en_d;
  logic [15:0]                 tx_cnt_q, tx_cnt_d;
  logic                        last_beat;

  assign last_beat = (idx_q == LAST_IDX);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    tvalid_d = tvalid_q;
    tx_en_d  = tx_en_q;
    tx_cnt_d = tx_cnt_q;
    if (!i_channel_up) begin
      // Transceiver is held in reset: abandon the frame without counting it.
      state_d  = TX_IDLE;
      tvalid_d = 1'b0;
      tx_en_d  = 1'b0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          tx_en_d = 1'b1;
          if (i_sfp_start_flag && tx_en_q) begin
            shreg_d  = i_tx_frame;
            idx_d    = '0;
            tvalid_d = 1'b1;
            tx_en_d  = 1'b0;
            state_d  = TX_SEND;
          end
        end
        TX_SEND: begin
          tx_en_d = 1'b0;
          if (tvalid_q && m_axis_tready) begin
            shreg_d = shreg_q << C_STREAM_WIDTH;
            idx_d   = idx_q + 1'b1;
            if (last_beat) begin
              // Ready is raised as the FSM returns to idle so start-to-start is N+1.
              tvalid_d = 1'b0;
              tx_en_d  = 1'b1;
              tx_cnt_d = tx_cnt_q + 16'd1;
              state_d  = TX_IDLE;
            end
          end
        end
        default: state_d = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q  <= TX_IDLE;
      shreg_q  <= '0;
      idx_q    <= '0;
      tvalid_q <= 1'b0;
      tx_en_q  <= 1'b0;
      tx_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      tvalid_q <= tvalid_d;
      tx_en_q  <= tx_en_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  assign o_tx_en        = tx_en_q;
  assign m_axis_tdata   = shreg_q[C_DATA_FRAME_BIT-1 -: C_STREAM_WIDTH];
  assign m_axis_tvalid  = tvalid_q;
  assign m_axis_tlast   = tvalid_q & last_beat;
  assign o_tx_frame_cnt = tx_cnt_q;

  sfp_rx_assembler #(
    .C_DATA_FRAME_BIT (C_DATA_FRAME_BIT),
    .C_STREAM_WIDTH   (C_STREAM_WIDTH),
    .C_RX_TIMEOUT     (C_RX_TIMEOUT)
  ) u_rx (
    .clk            (S_AXI_ACLK),
    .rst_n          (S_AXI_ARESETN),
    .i_channel_up   (i_channel_up),
    .i_tdata        (s_axis_tdata),
    .i_tvalid       (s_axis_tvalid),
    .i_tlast        (s_axis_tlast),
    .o_rx_frame     (o_rx_frame),
    .o_end_flag     (o_sfp_end_flag),
    .o_rx_err       (o_rx_err),
    .o_rx_frame_cnt (o_rx_frame_cnt),
    .o_rx_err_cnt   (o_rx_err_cnt)
  );

endmodule

// File: tb/tb_sfp_frame_link.sv
module tb_sfp_frame_link;

  localparam int FB  = 128;
  localparam int SW  = 32;
  localparam int NW  = FB / SW;
  localparam int TMO = 255;

  logic          clk;
  logic          rst_n;
  logic          chan_up;
  logic          start;
  logic [FB-1:0] tx_frame;
  logic          tx_en;
  logic [SW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic [SW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic [FB-1:0] rx_frame;
  logic          end_flag;
  logic          rx_err;
  logic [15:0]   tx_cnt;
  logic [15:0]   rx_cnt;
  logic [15:0]   err_cnt;

  logic ready_force;
  logic rnd_ready;
  int   ready_mode;
  assign m_tready = (ready_mode == 1) ? rnd_ready : ready_force;

  sfp_frame_link #(
    .C_DATA_FRAME_BIT (FB),
    .C_STREAM_WIDTH   (SW),
    .C_RX_TIMEOUT     (TMO)
  ) dut (
    .S_AXI_ACLK       (clk),
    .S_AXI_ARESETN    (rst_n),
    .i_channel_up     (chan_up),
    .i_sfp_start_flag (start),
    .i_tx_frame       (tx_frame),
    .o_tx_en          (tx_en),
    .m_axis_tdata     (m_tdata),
    .m_axis_tvalid    (m_tvalid),
    .m_axis_tlast     (m_tlast),
    .m_axis_tready    (m_tready),
    .s_axis_tdata     (s_tdata),
    .s_axis_tvalid    (s_tvalid),
    .s_axis_tlast     (s_tlast),
    .o_rx_frame       (rx_frame),
    .o_sfp_end_flag   (end_flag),
    .o_rx_err         (rx_err),
    .o_tx_frame_cnt   (tx_cnt),
    .o_rx_frame_cnt   (rx_cnt),
    .o_rx_err_cnt     (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [SW-1:0] data;
    logic          last;
  } tx_exp_t;

  typedef struct {
    logic          err;
    logic [FB-1:0] frame;
  } rx_exp_t;

  tx_exp_t       tx_q[$];
  rx_exp_t       rx_q[$];
  logic [SW-1:0] rx_words[$];

  int checks;
  int errors;
  int tx_sent;
  int rx_good;
  int rx_bad;

  task automatic chk(input string name, input logic [FB-1:0] act, input logic [FB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected words of one frame, most significant word first.
  task automatic push_tx(input logic [FB-1:0] fr);
    tx_exp_t e;
    for (int i = 0; i < NW; i++) begin
      e.data = fr[FB-1-i*SW -: SW];
      e.last = (i == NW - 1);
      tx_q.push_back(e);
    end
    tx_sent++;
  endtask

  task automatic wait_tx_en();
    int n;
    n = 0;
    @(negedge clk);
    while (!tx_en && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tx_en_wait", tx_en, 1'b1);
  endtask

  // Start a frame and watch o_tx_en cycle by cycle with a scripted tready window.
  task automatic tx_directed(input logic [FB-1:0] fr, input int stall_lo, input int stall_hi,
                             input int extra_k, input int idle_k, input logic [SW-1:0] hold_word);
    wait_tx_en();
    @(posedge clk); #1;
    tx_frame = fr;
    start    = 1'b1;
    push_tx(fr);
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= idle_k; k++) begin
      ready_force = !(k >= stall_lo && k <= stall_hi);
      start       = (k == extra_k);
      tx_frame    = ~fr;
      @(negedge clk);
      chk("tx_en_busy", tx_en, (k == idle_k));
      if (k >= stall_lo && k <= stall_hi) chk("tx_hold_data", m_tdata, hold_word);
      @(posedge clk); #1;
    end
    start       = 1'b0;
    ready_force = 1'b1;
  endtask

  // Drive rx_words as one burst; the expected outcome follows from the length alone.
  task automatic rx_send(input int unsigned max_gap, input bit no_tlast);
    logic [FB-1:0] fr;
    rx_exp_t       e;
    int            n;
    int unsigned   gap;
    fr = '0;
    n  = rx_words.size();
    for (int i = 0; i < n; i++) begin
      gap      = $urandom_range(max_gap, 0);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
      s_tvalid = 1'b1;
      s_tdata  = rx_words[i];
      s_tlast  = !no_tlast && (i == n - 1);
      fr       = (fr << SW) | FB'(rx_words[i]);
      if (!no_tlast && i == ((n < NW) ? n : NW) - 1) begin
        e.err   = (n != NW);
        e.frame = fr;
        rx_q.push_back(e);
        if (n == NW) rx_good++;
        else rx_bad++;
      end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic fill_rx_random(input int n);
    rx_words.delete();
    for (int i = 0; i < n; i++) rx_words.push_back($urandom);
  endtask

  task automatic tx_rand(input int cnt);
    logic [FB-1:0] fr;
    for (int i = 0; i < cnt; i++) begin
      wait_tx_en();
      fr = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
      tx_frame = fr;
      start    = 1'b1;
      push_tx(fr);
      @(posedge clk); #1;
      start = 1'b0;
      repeat ($urandom_range(3, 0)) @(posedge clk);
    end
  endtask

  task automatic rx_rand(input int cnt);
    int len;
    for (int i = 0; i < cnt; i++) begin
      len = ($urandom_range(9, 0) < 6) ? NW : int'($urandom_range(6, 1));
      fill_rx_random(len);
      rx_send(3, 1'b0);
      repeat ($urandom_range(2, 0)) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    logic [FB-1:0] saved;
    int            first_k;
    int            n;
    checks = 0; errors = 0; tx_sent = 0; rx_good = 0; rx_bad = 0;
    rst_n = 1'b0; chan_up = 1'b0; start = 1'b0; tx_frame = '0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    ready_force = 1'b1; rnd_ready = 1'b1; ready_mode = 0;

    fork
      forever begin
        @(posedge clk); #1;
        rnd_ready = 1'($urandom_range(1, 0));
      end
      begin : tx_monitor
        tx_exp_t te;
        forever begin
          @(negedge clk);
          if (rst_n && m_tvalid && m_tready) begin
            if (tx_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL tx_unexpected: got word %0h with no word expected", m_tdata);
            end else begin
              te = tx_q.pop_front();
              chk("tx_data", m_tdata, te.data);
              chk("tx_last", m_tlast, te.last);
            end
          end
        end
      end
      begin : rx_monitor
        rx_exp_t re;
        forever begin
          @(negedge clk);
          if (rst_n && (end_flag || rx_err)) begin
            if (rx_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL rx_unexpected: got end %0b err %0b with no event expected", end_flag, rx_err);
            end else begin
              re = rx_q.pop_front();
              chk("rx_kind_err", rx_err, re.err);
              chk("rx_kind_end", end_flag, !re.err);
              if (!re.err) chk("rx_frame", rx_frame, re.frame);
            end
          end
        end
      end
    join_none

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_tx_en", tx_en, 1'b0);
    chk("rst_tvalid", m_tvalid, 1'b0);
    chk("rst_tlast", m_tlast, 1'b0);
    chk("rst_tdata", m_tdata, '0);
    chk("rst_rx_frame", rx_frame, '0);
    chk("rst_end", end_flag, 1'b0);
    chk("rst_err", rx_err, 1'b0);
    chk("rst_cnts", {tx_cnt, rx_cnt, err_cnt}, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("tx_en_link_down", tx_en, 1'b0);
    @(posedge clk); #1;
    chan_up = 1'b1;
    @(negedge clk);
    chk("tx_en_first_up", tx_en, 1'b0);
    @(negedge clk);
    chk("tx_en_registered", tx_en, 1'b1);

    // TX basic and TX with back-pressure plus an ignored start
    tx_directed(128'h0001_0002_1111_1111_2222_2222_3333_3333, 99, 0, 0, 5, '0);
    chk("tx_cnt_basic", tx_cnt, 16'd1);
    tx_directed(128'h0001_0002_1111_1111_2222_2222_3333_3333, 2, 4, 3, 8, 32'h1111_1111);
    chk("tx_cnt_bp", tx_cnt, 16'd2);

    // RX good frame with exact end-flag timing
    rx_words = '{32'hA, 32'hB, 32'hC, 32'hD};
    rx_send(0, 1'b0);
    @(negedge clk);
    chk("rx_end_t1", end_flag, 1'b1);
    chk("rx_frame_abcd", rx_frame, 128'h0000000A_0000000B_0000000C_0000000D);
    @(negedge clk);
    chk("rx_end_t2", end_flag, 1'b0);
    chk("rx_cnt_one", rx_cnt, 16'd1);

    // Short, long, then good
    saved = rx_frame;
    rx_words = '{32'h1, 32'h2, 32'h3};
    rx_send(0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rx_frame_held_short", rx_frame, saved);
    fill_rx_random(6);
    rx_send(1, 1'b0);
    repeat (2) @(negedge clk);
    chk("rx_frame_held_long", rx_frame, saved);
    @(posedge clk); #1;
    fill_rx_random(NW);
    rx_send(2, 1'b0);
    repeat (3) @(negedge clk);
    chk("rx_err_cnt_two", err_cnt, 16'd2);
    chk("rx_cnt_two", rx_cnt, 16'd2);

    // Timeout after two beats
    @(posedge clk); #1;
    fill_rx_random(2);
    rx_send(0, 1'b1);
    rx_q.push_back('{err: 1'b1, frame: '0});
    rx_bad++;
    first_k = 0;
    for (int k = 1; k <= 300 && first_k == 0; k++) begin
      @(negedge clk);
      if (rx_err) first_k = k;
    end
    chk("rx_timeout_window", (first_k >= TMO && first_k <= TMO + 1), 1'b1);
    @(posedge clk); #1;
    fill_rx_random(NW);
    rx_send(0, 1'b0);
    repeat (3) @(negedge clk);
    chk("rx_err_cnt_tmo", err_cnt, 16'd3);
    chk("rx_cnt_after_tmo", rx_cnt, 16'd3);

    // RX partial frame aborted by link drop: no error
    @(posedge clk); #1;
    fill_rx_random(2);
    rx_send(0, 1'b1);
    chan_up = 1'b0;
    @(posedge clk); #1;
    chan_up = 1'b1;
    fill_rx_random(NW);
    rx_send(1, 1'b0);
    repeat (3) @(negedge clk);
    chk("rx_err_cnt_linkdrop", err_cnt, 16'd3);
    chk("rx_cnt_linkdrop", rx_cnt, 16'd4);

    // TX link drop after beat 2
    wait_tx_en();
    @(posedge clk); #1;
    tx_frame = 128'hDEAD_BEEF_CAFE_F00D_0123_4567_89AB_CDEF;
    start    = 1'b1;
    push_tx(tx_frame);
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chan_up     = 1'b0;
    ready_force = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("drop_tvalid", m_tvalid, 1'b0);
    chk("drop_tx_en", tx_en, 1'b0);
    chk("drop_words_left", tx_q.size(), 2);
    tx_q.delete();
    tx_sent--;
    repeat (3) @(posedge clk); #1;
    chk("drop_tx_en_held", tx_en, 1'b0);
    chan_up     = 1'b1;
    ready_force = 1'b1;
    @(negedge clk);
    chk("restore_tx_en_lag", tx_en, 1'b0);
    @(negedge clk);
    chk("restore_tx_en", tx_en, 1'b1);
    chk("drop_tx_cnt", tx_cnt, 16'd2);
    tx_directed(128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100, 99, 0, 0, 5, '0);
    chk("restore_tx_cnt", tx_cnt, 16'd3);

    // Randomized traffic on both directions
    ready_mode = 1;
    fork
      tx_rand(25);
      rx_rand(30);
    join
    n = 0;
    while ((tx_q.size() != 0 || rx_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_tx_q", tx_q.size(), 0);
    chk("drain_rx_q", rx_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("final_tx_cnt", tx_cnt, 16'(tx_sent));
    chk("final_rx_cnt", rx_cnt, 16'(rx_good));
    chk("final_err_cnt", err_cnt, 16'(rx_bad));
    ready_mode = 0;

    // Reset asserted mid-frame
    ready_force = 1'b0;
    wait_tx_en();
    @(posedge clk); #1;
    tx_frame = {$urandom, $urandom, $urandom, $urandom};
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("midrst_busy", m_tvalid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_tvalid", m_tvalid, 1'b0);
    chk("midrst_tx_en", tx_en, 1'b0);
    chk("midrst_rx_frame", rx_frame, '0);
    chk("midrst_cnts", {tx_cnt, rx_cnt, err_cnt}, '0);
    repeat (2) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
